count_sequence_monitor: RTL

COUNT_SEQUENCE_MONITOR -- requirements
Module: count_sequence_monitor

---
 rtl/count_monitor_pkg.sv | 18 +
 rtl/count_predictor.sv | 84 ++++++++
 rtl/count_sequence_monitor.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/count_monitor_pkg.sv
// rtl/count_monitor_pkg.sv - shared state, direction and statistics constants for count_sequence_monitor
package count_monitor_pkg;

  // FSM state encoding, exposed on the state output
  localparam logic [1:0] ST_ACQUIRE = 2'd0;
  localparam logic [1:0] ST_LOCKED  = 2'd1;
  localparam logic [1:0] ST_FAULT   = 2'd2;

  // Expected-sequence direction codes
  localparam logic [1:0] DIR_UP      = 2'd0;
  localparam logic [1:0] DIR_DOWN    = 2'd1;
  localparam logic [1:0] DIR_REVERSE = 2'd2;

  // Statistics counter widths
  localparam int WRAPS_W  = 16;
  localparam int ERRORS_W = 8;

endpackage

// File: rtl/count_predictor.sv
// rtl/count_predictor.sv - combinational next-value check for the upstream counter sequence
module count_predictor
  import count_monitor_pkg::*;
#(
  parameter int         max    = 16,
  parameter int         digits = 4,
  parameter logic [1:0] dir    = DIR_UP
) (
  input  logic [digits-1:0] i_prev,
  input  logic              i_heading,        // reverse: 1 = next step expected upward
  input  logic              i_heading_valid,  // reverse: heading known
  input  logic [digits-1:0] i_sample,
  output logic              o_match,
  output logic              o_heading,        // heading to keep after a matching step
  output logic              o_sync_heading,   // heading re-derived from the sample alone
  output logic              o_sync_valid,
  output logic              o_wrap            // step is a period boundary
);

  localparam logic [digits-1:0] LAST = digits'(max - 1);
  localparam logic [digits-1:0] ONE  = digits'(1);
  localparam logic [digits-1:0] ZERO = '0;

  logic              w_sample_ok;
  logic              w_prev_ok;
  logic              w_up_step;
  logic              w_dn_step;
  logic              w_base;
  logic [digits-1:0] w_inc;
  logic [digits-1:0] w_dec;

  // Compare the sample with the legal successor(s) of the previous value
  always_comb begin
    w_sample_ok    = 32'(i_sample) < 32'(max);
    // An out-of-range previous value has no legal successor
    w_prev_ok      = 32'(i_prev) < 32'(max);
    w_inc          = i_prev + ONE;
    w_dec          = i_prev - ONE;
    w_up_step      = (i_sample == w_inc) && (i_prev != LAST);
    w_dn_step      = (i_sample == w_dec) && (i_prev != ZERO);
    w_base         = 1'b0;
    o_wrap         = 1'b0;
    o_heading      = i_heading;
    o_sync_heading = 1'b0;
    o_sync_valid   = 1'b0;

    case (dir)
      DIR_UP: begin
        w_base = (i_prev == LAST) ? (i_sample == ZERO) : w_up_step;
        o_wrap = (i_prev == LAST) && (i_sample == ZERO);
      end
      DIR_DOWN: begin
        w_base = (i_prev == ZERO) ? (i_sample == LAST) : w_dn_step;
        o_wrap = (i_prev == ZERO) && (i_sample == LAST);
      end
      default: begin
        // Unknown heading accepts either neighbour; the step taken fixes it
        w_base = i_heading_valid ? (i_heading ? w_up_step : w_dn_step)
                                 : (w_up_step || w_dn_step);
        o_wrap = (i_sample == ZERO);
      end
    endcase

    // Heading flips at the endpoints, otherwise follows the step direction
    if (i_sample == LAST) begin
      o_heading = 1'b0;
    end else if (i_sample == ZERO) begin
      o_heading = 1'b1;
    end else begin
      o_heading = i_heading_valid ? i_heading : w_up_step;
    end

    if (i_sample == ZERO) begin
      o_sync_heading = 1'b1;
      o_sync_valid   = 1'b1;
    end else if (i_sample == LAST) begin
      o_sync_heading = 1'b0;
      o_sync_valid   = 1'b1;
    end

    o_match = w_base && w_sample_ok && w_prev_ok;
  end

endmodule

// File: rtl/count_sequence_monitor.sv
// rtl/count_sequence_monitor.sv - lock/fault monitor for an upstream counter; statistics under COUNT_MONITOR_STATS_EN
module count_sequence_monitor
  import count_monitor_pkg::*;
#(
  parameter int    max       = 16,
  parameter int    digits    = 4,
  parameter string direction = "up",
  parameter int    lock_len  = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [digits-1:0]   count,
  input  logic                clear,
  output logic                locked,
  output logic                error,
  output logic                wrap,
  output logic [WRAPS_W-1:0]  wraps,
  output logic [ERRORS_W-1:0] errors,
  output logic [1:0]          state
);

  localparam logic [1:0] DIR = (direction == "down")    ? DIR_DOWN :
                               (direction == "reverse") ? DIR_REVERSE : DIR_UP;
  localparam int RUN_W = $clog2(lock_len + 1);

  logic [digits-1:0] r_prev;
  logic              r_prev_valid;
  logic              r_heading;
  logic              r_heading_valid;
  logic [1:0]        r_state;
  logic [RUN_W-1:0]  r_run;
  logic              r_locked;
  logic              r_error;
  logic              r_wrap;

  logic w_match;
  logic w_next_heading;
  logic w_sync_heading;
  logic w_sync_valid;
  logic w_wrap_step;
  logic w_in_locked;
  logic w_err_set;
  logic w_wrap_set;
  logic w_run_done;

  count_predictor #(
    .max    (max),
    .digits (digits),
    .dir    (DIR)
  ) u_predictor (
    .i_prev          (r_prev),
    .i_heading       (r_heading),
    .i_heading_valid (r_heading_valid),
    .i_sample        (count),
    .o_match         (w_match),
    .o_heading       (w_next_heading),
    .o_sync_heading  (w_sync_heading),
    .o_sync_valid    (w_sync_valid),
    .o_wrap          (w_wrap_step)
  );

  assign w_in_locked = r_prev_valid && (r_state == ST_LOCKED);
  assign w_err_set   = w_in_locked && !w_match;
  assign w_wrap_set  = w_in_locked && w_match && w_wrap_step;
  assign w_run_done  = (32'(r_run) + 32'd1) >= 32'(lock_len);

  // Sequence tracking FSM; every sample becomes the next prev
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_prev          <= '0;
      r_prev_valid    <= 1'b0;
      r_heading       <= 1'b0;
      r_heading_valid <= 1'b0;
      r_state         <= ST_ACQUIRE;
      r_run           <= '0;
      r_locked        <= 1'b0;
      r_error         <= 1'b0;
      r_wrap          <= 1'b0;
    end else begin
      r_prev  <= count;
      r_error <= w_err_set;
      r_wrap  <= w_wrap_set;
      if (!r_prev_valid) begin
        r_prev_valid    <= 1'b1;
        r_heading       <= w_sync_heading;
        r_heading_valid <= w_sync_valid;
      end else begin
        case (r_state)
          ST_ACQUIRE: begin
            if (w_match) begin
              r_run           <= r_run + RUN_W'(1);
              r_heading       <= w_next_heading;
              r_heading_valid <= 1'b1;
              if (w_run_done) begin
                r_state  <= ST_LOCKED;
                r_locked <= 1'b1;
              end
            end else begin
              r_run           <= '0;
              r_heading       <= w_sync_heading;
              r_heading_valid <= w_sync_valid;
            end
          end
          ST_LOCKED: begin
            if (w_match) begin
              r_heading       <= w_next_heading;
              r_heading_valid <= 1'b1;
            end else begin
              r_state  <= ST_FAULT;
              r_locked <= 1'b0;
            end
          end
          default: begin
            // One-cycle fault: resynchronise on the current sample
            r_state         <= ST_ACQUIRE;
            r_run           <= '0;
            r_heading       <= w_sync_heading;
            r_heading_valid <= w_sync_valid;
          end
        endcase
      end
    end
  end

  assign locked = r_locked;
  assign error  = r_error;
  assign wrap   = r_wrap;
  assign state  = r_state;

`ifdef COUNT_MONITOR_STATS_EN
  logic [WRAPS_W-1:0]  r_wraps;
  logic [ERRORS_W-1:0] r_errors;

  // Period and violation counters; clear takes priority over a same-cycle event
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wraps  <= '0;
      r_errors <= '0;
    end else if (clear) begin
      r_wraps  <= '0;
      r_errors <= '0;
    end else begin
      if (w_wrap_set) begin
        r_wraps <= r_wraps + WRAPS_W'(1);
      end
      if (w_err_set && (r_errors != {ERRORS_W{1'b1}})) begin
        r_errors <= r_errors + ERRORS_W'(1);
      end
    end
  end

  assign wraps  = r_wraps;
  assign errors = r_errors;
`else
  logic w_unused_clear;
  assign w_unused_clear = clear;
  assign wraps          = '0;
  assign errors         = '0;
`endif

endmodule
